// File: rtl/usrt_pkg.sv
// Shared state encoding, datapath width and parameter defaults for the USRT
// transfer controller and its rx holding register.
package usrt_pkg;

  localparam int unsigned USRT_DW             = 8;
  localparam int unsigned USRT_RD_TIMEOUT_DEF = 1024;
  localparam int unsigned USRT_URST_CYC_DEF   = 2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_WAIT = 3'd1,
    ST_WR_DONE = 3'd2,
    ST_RD_WAIT = 3'd3,
    ST_RSTP    = 3'd4
  } usrt_state_e;

  // Counter width that stays at least one bit wide for a limit of 1.
  function automatic int unsigned cnt_width(input int unsigned limit);
    return (limit > 1) ? $clog2(limit) : 1;
  endfunction

endpackage

// File: rtl/usrt_rx_buf.sv
// One-entry holding register for deserializer bytes, with a sticky overrun
// flag. A pop and a push in the same cycle hand over to the new byte cleanly.
module usrt_rx_buf
  import usrt_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clr_i,
  input  logic               push_i,
  input  logic [USRT_DW-1:0] push_data_i,
  input  logic               pop_i,
  output logic               full_o,
  output logic [USRT_DW-1:0] data_o,
  output logic               ovr_o
);

  logic               full_q, full_d;
  logic               ovr_q, ovr_d;
  logic [USRT_DW-1:0] data_q, data_d;

  always_comb begin
    full_d = full_q;
    ovr_d  = ovr_q;
    data_d = data_q;
    if (clr_i) begin
      full_d = 1'b0;
      ovr_d  = 1'b0;
      data_d = '0;
    end else if (pop_i) begin
      // The served byte takes its overrun status with it.
      ovr_d  = 1'b0;
      full_d = push_i;
      if (push_i) data_d = push_data_i;
    end else if (push_i) begin
      if (full_q) begin
        ovr_d = 1'b1;
      end else begin
        full_d = 1'b1;
        data_d = push_data_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      full_q <= 1'b0;
      ovr_q  <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      ovr_q  <= ovr_d;
      data_q <= data_d;
    end
  end

  assign full_o = full_q;
  assign data_o = data_q;
  assign ovr_o  = ovr_q;

endmodule

// File: rtl/usrt_xfer_ctrl.sv
// Sequences APB-style byte transfers into the serializer and out of the rx
// holding register; owns the datapath reset pulse and baud enable.
module usrt_xfer_ctrl
  import usrt_pkg::*;
#(
  parameter int unsigned RD_TIMEOUT = USRT_RD_TIMEOUT_DEF,
  parameter int unsigned URST_CYC   = USRT_URST_CYC_DEF
) (
  input  logic               pClk,
  input  logic               pReset,
  input  logic               pSelect,
  input  logic               pEnable,
  input  logic               pWrite,
  input  logic [USRT_DW-1:0] pWData,
  output logic [USRT_DW-1:0] pRData,
  output logic               pReady,
  output logic               pSlvErr,
  output logic [USRT_DW-1:0] tx_data,
  output logic               tx_start,
  input  logic               tx_busy,
  input  logic [USRT_DW-1:0] rx_data,
  input  logic               rx_valid,
  output logic               baud_en,
  output logic               uRst
);

  localparam int unsigned CW = cnt_width(RD_TIMEOUT);
  localparam int unsigned UW = $clog2(URST_CYC + 1);
  localparam logic [CW-1:0] TO_MAX  = CW'(RD_TIMEOUT - 1);
  localparam logic [UW-1:0] URST_LD = UW'(URST_CYC);

  usrt_state_e        state_q, state_d;
  logic [USRT_DW-1:0] tx_data_q, tx_data_d;
  logic               dir_q, dir_d;
  logic [CW-1:0]      to_cnt_q, to_cnt_d;
  logic [UW-1:0]      urst_cnt_q;
  logic               enter_rstp;
  logic               abort;
  logic               rx_pop;
  logic               rx_full;
  logic               rx_ovr;
  logic [USRT_DW-1:0] rx_buf;

  // Bus handshake: an access starts on pSelect&pEnable in IDLE; the master
  // must then hold pSelect, pEnable and pWrite until pReady pulses for one
  // cycle, and pRData/pSlvErr are meaningful only in that pReady cycle.
  // Dropping or flipping any of them while waiting aborts the transfer.
  assign abort = !pSelect || !pEnable || (pWrite != dir_q);

  always_comb begin
    state_d    = state_q;
    tx_data_d  = tx_data_q;
    dir_d      = dir_q;
    to_cnt_d   = to_cnt_q;
    tx_start   = 1'b0;
    pReady     = 1'b0;
    pRData     = '0;
    pSlvErr    = 1'b0;
    rx_pop     = 1'b0;
    enter_rstp = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (pSelect && pEnable) begin
          dir_d = pWrite;
          if (pWrite) begin
            tx_data_d = pWData;
            state_d   = ST_WR_WAIT;
          end else begin
            to_cnt_d = '0;
            state_d  = ST_RD_WAIT;
          end
        end
      end
      ST_WR_WAIT: begin
        // Completion is checked before abort so it wins a same-cycle tie.
        if (!tx_busy) begin
          tx_start = 1'b1;
          state_d  = ST_WR_DONE;
        end else if (abort) begin
          enter_rstp = 1'b1;
          state_d    = ST_RSTP;
        end
      end
      ST_WR_DONE: begin
        pReady  = 1'b1;
        state_d = ST_IDLE;
      end
      ST_RD_WAIT: begin
        if (rx_full) begin
          pReady  = 1'b1;
          pRData  = rx_buf;
          pSlvErr = rx_ovr;
          rx_pop  = 1'b1;
          state_d = ST_IDLE;
        end else if (to_cnt_q == TO_MAX) begin
          pReady  = 1'b1;
          pSlvErr = 1'b1;
          state_d = ST_IDLE;
        end else if (abort) begin
          enter_rstp = 1'b1;
          state_d    = ST_RSTP;
        end else begin
          to_cnt_d = to_cnt_q + CW'(1);
        end
      end
      ST_RSTP: begin
        if (urst_cnt_q <= UW'(1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge pClk) begin
    if (pReset) begin
      state_q   <= ST_IDLE;
      tx_data_q <= '0;
      dir_q     <= 1'b0;
      to_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      tx_data_q <= tx_data_d;
      dir_q     <= dir_d;
      to_cnt_q  <= to_cnt_d;
    end
  end

  // Datapath reset pulse, shared by bus reset release and protocol aborts.
  always_ff @(posedge pClk) begin
    if (pReset || enter_rstp) begin
      urst_cnt_q <= URST_LD;
    end else if (urst_cnt_q != '0) begin
      urst_cnt_q <= urst_cnt_q - UW'(1);
    end
  end

  assign uRst    = (urst_cnt_q != '0);
  assign baud_en = !uRst;
  assign tx_data = tx_data_q;

  usrt_rx_buf u_rx_buf (
    .clk_i       (pClk),
    .rst_i       (pReset),
    .clr_i       (state_q == ST_RSTP),
    .push_i      (rx_valid),
    .push_data_i (rx_data),
    .pop_i       (rx_pop),
    .full_o      (rx_full),
    .data_o      (rx_buf),
    .ovr_o       (rx_ovr)
  );

endmodule

// File: tb/tb_usrt_xfer_ctrl.sv
// Directed bench for usrt_xfer_ctrl: writes, reads, timeouts, overrun,
// same-cycle buffer handover, protocol aborts and mid-transfer reset.
module tb_usrt_xfer_ctrl;

  localparam int unsigned RD_TO  = 8;
  localparam int unsigned URST_N = 2;

  logic       pClk;
  logic       pReset;
  logic       pSelect;
  logic       pEnable;
  logic       pWrite;
  logic [7:0] pWData;
  logic [7:0] pRData;
  logic       pReady;
  logic       pSlvErr;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       baud_en;
  logic       uRst;

  int n_vec = 0;
  int n_err = 0;

  usrt_xfer_ctrl #(.RD_TIMEOUT(RD_TO), .URST_CYC(URST_N)) dut (
    .pClk     (pClk),
    .pReset   (pReset),
    .pSelect  (pSelect),
    .pEnable  (pEnable),
    .pWrite   (pWrite),
    .pWData   (pWData),
    .pRData   (pRData),
    .pReady   (pReady),
    .pSlvErr  (pSlvErr),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .tx_busy  (tx_busy),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .baud_en  (baud_en),
    .uRst     (uRst)
  );

  // Clock and reset-time input defaults.
  initial begin
    pClk = 1'b0;
    forever #5 pClk = ~pClk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks: all start and end 1 time unit after a rising edge.
  task automatic tick();
    @(posedge pClk);
    #1;
  endtask

  task automatic rx_push(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  // Setup cycle, then access cycles c=0.. until pReady or a cycle budget.
  task automatic apb_xfer(input logic wr, input logic [7:0] wd, input int busy_cyc,
                          input int rx_cyc, input logic [7:0] rx_byte,
                          output logic got, output logic [7:0] rd, output logic err,
                          output int acc, output int n_start, output int start_cyc,
                          output logic [7:0] start_data);
    got = 1'b0; rd = 8'h00; err = 1'b0; acc = -1;
    n_start = 0; start_cyc = -1; start_data = 8'h00;
    pSelect = 1'b1; pEnable = 1'b0; pWrite = wr; pWData = wd;
    tick();
    pEnable = 1'b1;
    for (int c = 0; c < 64 && !got; c++) begin
      tx_busy  = (c < busy_cyc);
      rx_valid = (c == rx_cyc);
      rx_data  = (c == rx_cyc) ? rx_byte : 8'h00;
      @(negedge pClk);
      if (tx_start) begin n_start++; start_cyc = c; start_data = tx_data; end
      if (pReady) begin got = 1'b1; rd = pRData; err = pSlvErr; acc = c; end
      tick();
    end
    pSelect = 1'b0; pEnable = 1'b0; pWrite = 1'b0;
    tx_busy = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
  endtask

  task automatic test_reset();
    pReset = 1'b1; pSelect = 1'b0; pEnable = 1'b0; pWrite = 1'b0; pWData = 8'h00;
    tx_busy = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) tick();
    @(negedge pClk);
    n_vec++; if (uRst !== 1'b1) begin n_err++; $display("FAIL rst uRst: got %b expected 1", uRst); end
    n_vec++; if (baud_en !== 1'b0) begin n_err++; $display("FAIL rst baud_en: got %b expected 0", baud_en); end
    n_vec++; if ({pReady, pSlvErr, tx_start} !== 3'b000) begin n_err++; $display("FAIL rst strobes: got %b expected 000", {pReady, pSlvErr, tx_start}); end
    n_vec++; if ({pRData, tx_data} !== 16'h0000) begin n_err++; $display("FAIL rst data: got %h expected 0000", {pRData, tx_data}); end
    tick();
    pReset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge pClk);
      n_vec++; if (uRst !== (c < URST_N)) begin n_err++; $display("FAIL rst_rel uRst c%0d: got %b expected %b", c, uRst, (c < URST_N)); end
      n_vec++; if (baud_en !== !(c < URST_N)) begin n_err++; $display("FAIL rst_rel baud_en c%0d: got %b expected %b", c, baud_en, !(c < URST_N)); end
      tick();
    end
  endtask

  task automatic test_write(input string name, input logic [7:0] d, input int busy, input int exp_start);
    logic got, err; logic [7:0] rd, sd; int acc, ns, sc;
    apb_xfer(1'b1, d, busy, -1, 8'h00, got, rd, err, acc, ns, sc, sd);
    n_vec++; if (got !== 1'b1) begin n_err++; $display("FAIL %s ready: got %b expected 1", name, got); end
    n_vec++; if (ns != 1) begin n_err++; $display("FAIL %s start_count: got %0d expected 1", name, ns); end
    n_vec++; if (sc != exp_start) begin n_err++; $display("FAIL %s start_cycle: got %0d expected %0d", name, sc, exp_start); end
    n_vec++; if (sd !== d) begin n_err++; $display("FAIL %s tx_data: got %h expected %h", name, sd, d); end
    n_vec++; if (acc != exp_start + 1) begin n_err++; $display("FAIL %s ready_cycle: got %0d expected %0d", name, acc, exp_start + 1); end
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL %s slverr: got %b expected 0", name, err); end
    @(negedge pClk);
    n_vec++; if ({pReady, tx_start} !== 2'b00) begin n_err++; $display("FAIL %s after: got %b expected 00", name, {pReady, tx_start}); end
    tick();
  endtask

  task automatic do_read(input string name, input int rx_cyc, input logic [7:0] rx_byte,
                         input logic [7:0] exp_d, input logic exp_e, input int exp_acc);
    logic got, err; logic [7:0] rd, sd; int acc, ns, sc;
    apb_xfer(1'b0, 8'h00, 0, rx_cyc, rx_byte, got, rd, err, acc, ns, sc, sd);
    n_vec++; if (got !== 1'b1) begin n_err++; $display("FAIL %s ready: got %b expected 1", name, got); end
    n_vec++; if (rd !== exp_d) begin n_err++; $display("FAIL %s rdata: got %h expected %h", name, rd, exp_d); end
    n_vec++; if (err !== exp_e) begin n_err++; $display("FAIL %s slverr: got %b expected %b", name, err, exp_e); end
    n_vec++; if (acc != exp_acc) begin n_err++; $display("FAIL %s ready_cycle: got %0d expected %0d", name, acc, exp_acc); end
    @(negedge pClk);
    n_vec++; if ({pReady, pSlvErr, pRData} !== 10'h000) begin n_err++; $display("FAIL %s after: got %h expected 000", name, {pReady, pSlvErr, pRData}); end
    tick();
  endtask

  task automatic test_read();
    rx_push(8'h5A);
    do_read("rd_hit", -1, 8'h00, 8'h5A, 1'b0, 1);
    do_read("rd_timeout", -1, 8'h00, 8'h00, 1'b1, RD_TO);
    do_read("rd_late", 3, 8'h66, 8'h66, 1'b0, 4);
  endtask

  task automatic test_overrun();
    rx_push(8'h11);
    rx_push(8'h22);
    do_read("ovr_first", -1, 8'h00, 8'h11, 1'b1, 1);
    do_read("ovr_empty", -1, 8'h00, 8'h00, 1'b1, RD_TO);
    rx_push(8'h33);
    do_read("ovr_cleared", -1, 8'h00, 8'h33, 1'b0, 1);
  endtask

  task automatic test_back_to_back();
    rx_push(8'h44);
    do_read("b2b_first", 1, 8'h55, 8'h44, 1'b0, 1);
    do_read("b2b_second", -1, 8'h00, 8'h55, 1'b0, 1);
  endtask

  // kind: 0 drops pSelect, 1 drops pEnable, 2 flips pWrite.
  task automatic test_abort(input string name, input logic wr, input int drop_cyc,
                            input int kind, input int busy_cyc, input logic exp_done);
    int n_rdy, n_st, n_urst, first_urst; logic bad_baud;
    n_rdy = 0; n_st = 0; n_urst = 0; first_urst = -1; bad_baud = 1'b0;
    if (wr) rx_push(8'h77);
    pSelect = 1'b1; pEnable = 1'b0; pWrite = wr; pWData = 8'hE1;
    tick();
    pEnable = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tx_busy = (c < busy_cyc);
      if (c == drop_cyc) begin
        if (kind == 0) pSelect = 1'b0;
        else if (kind == 1) pEnable = 1'b0;
        else pWrite = ~wr;
      end
      if (c == drop_cyc + 1) begin pSelect = 1'b0; pEnable = 1'b0; pWrite = 1'b0; end
      @(negedge pClk);
      if (pReady) n_rdy++;
      if (tx_start) n_st++;
      if (uRst) begin n_urst++; if (first_urst < 0) first_urst = c; end
      if (baud_en !== !uRst) bad_baud = 1'b1;
      tick();
    end
    tx_busy = 1'b0;
    n_vec++; if (n_rdy != int'(exp_done)) begin n_err++; $display("FAIL %s ready_count: got %0d expected %0d", name, n_rdy, exp_done); end
    n_vec++; if (n_st != int'(exp_done && wr)) begin n_err++; $display("FAIL %s start_count: got %0d expected %0d", name, n_st, exp_done && wr); end
    n_vec++; if (n_urst != (exp_done ? 0 : URST_N)) begin n_err++; $display("FAIL %s urst_cycles: got %0d expected %0d", name, n_urst, exp_done ? 0 : URST_N); end
    n_vec++; if (bad_baud !== 1'b0) begin n_err++; $display("FAIL %s baud_en: got %b expected 0 mismatched cycles", name, bad_baud); end
    if (!exp_done) begin
      n_vec++; if (first_urst != drop_cyc + 1) begin n_err++; $display("FAIL %s urst_start: got %0d expected %0d", name, first_urst, drop_cyc + 1); end
      do_read({name, "_rxbuf"}, -1, 8'h00, 8'h00, 1'b1, RD_TO);
    end else begin
      do_read({name, "_rxbuf"}, -1, 8'h00, 8'h77, 1'b0, 1);
    end
  endtask

  task automatic test_reset_mid();
    rx_push(8'h99);
    pSelect = 1'b1; pEnable = 1'b0; pWrite = 1'b1; pWData = 8'hC3; tx_busy = 1'b1;
    tick();
    pEnable = 1'b1;
    tick();
    tick();
    pReset = 1'b1; pSelect = 1'b0; pEnable = 1'b0; pWrite = 1'b0;
    @(negedge pClk);
    n_vec++; if (tx_data !== 8'hC3) begin n_err++; $display("FAIL rst_mid latched: got %h expected c3", tx_data); end
    tick();
    pReset = 1'b0; tx_busy = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge pClk);
      n_vec++; if (uRst !== (c < URST_N)) begin n_err++; $display("FAIL rst_mid uRst c%0d: got %b expected %b", c, uRst, (c < URST_N)); end
      n_vec++; if ({pReady, tx_start, tx_data} !== 10'h000) begin n_err++; $display("FAIL rst_mid outputs c%0d: got %h expected 000", c, {pReady, tx_start, tx_data}); end
      tick();
    end
    do_read("rst_mid_rxbuf", -1, 8'h00, 8'h00, 1'b1, RD_TO);
  endtask

  initial begin
    test_reset();
    test_write("wr_idle", 8'hA5, 0, 1);
    test_write("wr_busy", 8'h3C, 10, 10);
    test_read();
    test_overrun();
    test_back_to_back();
    test_abort("abort_wr_sel", 1'b1, 2, 0, 8, 1'b0);
    test_abort("abort_wr_en", 1'b1, 2, 1, 8, 1'b0);
    test_abort("abort_rd_dir", 1'b0, 2, 2, 0, 1'b0);
    test_abort("done_beats_abort", 1'b1, 1, 0, 1, 1'b1);
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
